// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit and the data RAM it drives.
package mem_lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned SELW = XLEN / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [XLEN-1:0] ZeroWord = '0;

  localparam logic RamCeOn    = 1'b1;
  localparam logic RamCeOff   = 1'b0;
  localparam logic RamWeWrite = 1'b1;
  localparam logic RamWeRead  = 1'b0;

  typedef struct packed {
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [REGW-1:0] rd;
  } lsu_req_t;

  // Legal RV32I load/store width encodings.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane alignment: lane select and write shift per beat, plus load extraction/extension.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]      offset,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  input  logic            beat,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] hi,
  output logic [SELW-1:0] sel_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] rdata_c,
  output logic            cross_c
);

  localparam int unsigned LANEW = 2 * SELW;
  localparam int unsigned WIDEW = 2 * XLEN;

  logic [LANEW-1:0] mask;
  logic [LANEW-1:0] lanes;
  logic [WIDEW-1:0] wide_w;
  logic [XLEN-1:0]  rd_shift;

  // Lanes and data are laid out across two words; the upper half is the second beat.
  always_comb begin
    case (size)
      2'b00:   mask = LANEW'(8'h01);
      2'b01:   mask = LANEW'(8'h03);
      default: mask = LANEW'(8'h0F);
    endcase
    lanes    = mask << offset;
    wide_w   = {ZeroWord, wdata} << {offset, 3'b000};
    rd_shift = XLEN'({hi, lo} >> {offset, 3'b000});
    sel_c    = beat ? lanes[LANEW-1:SELW] : lanes[SELW-1:0];
    wdata_c  = beat ? wide_w[WIDEW-1:XLEN] : wide_w[XLEN-1:0];
    cross_c  = |lanes[LANEW-1:SELW];
    case (size)
      2'b00:   rdata_c = {{(XLEN-8){sign_ext & rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   rdata_c = {{(XLEN-16){sign_ext & rd_shift[15]}}, rd_shift[15:0]};
      default: rdata_c = rd_shift;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one request at a time, split misaligned beats, extended load data.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [4:0]      req_rd,
  output logic            resp_valid,
  output logic            resp_we,
  output logic [31:0]     resp_rdata,
  output logic [4:0]      resp_rd,
  output logic            resp_err,
  output logic            stall_req,
  output logic            ram_ce,
  output logic            ram_we,
  output logic [31:0]     ram_addr,
  output logic [3:0]      ram_sel,
  output logic [31:0]     ram_wdata,
  input  logic [31:0]     ram_rdata
);

  logic [1:0]      state_q, state_d;
  lsu_req_t        req_q, req_d;
  logic [XLEN-1:0] lo_q, lo_d, hi_q, hi_d;

  logic            req_ready_d, stall_req_d;
  logic            resp_valid_d, resp_we_d, resp_err_d;
  logic [XLEN-1:0] resp_rdata_d;
  logic [REGW-1:0] resp_rd_d;
  logic            ram_ce_d, ram_we_d;
  logic [XLEN-1:0] ram_addr_d, ram_wdata_d;
  logic [SELW-1:0] ram_sel_d;

  logic            in_flight;
  logic [1:0]      al_offset, al_size;
  logic [XLEN-1:0] al_wdata, al_lo, al_hi;
  logic [SELW-1:0] al_sel_c;
  logic [XLEN-1:0] al_wdata_c, al_rdata_c;
  logic            al_cross_c;

  // Aligner sees the incoming request while idle (ACC0 beat) and the held request in flight.
  assign in_flight = (state_q == ST_ACC0) || (state_q == ST_ACC1);
  assign al_offset = in_flight ? req_q.addr[1:0]   : req_addr[1:0];
  assign al_size   = in_flight ? req_q.funct3[1:0] : req_funct3[1:0];
  assign al_wdata  = in_flight ? req_q.wdata       : req_wdata;
  assign al_lo     = (state_q == ST_ACC0) ? ram_rdata : lo_q;
  assign al_hi     = (state_q == ST_ACC1) ? ram_rdata : hi_q;

  lsu_align u_align (
    .offset   (al_offset),
    .size     (al_size),
    .sign_ext (~req_q.funct3[2]),
    .beat     (state_q == ST_ACC0),
    .wdata    (al_wdata),
    .lo       (al_lo),
    .hi       (al_hi),
    .sel_c    (al_sel_c),
    .wdata_c  (al_wdata_c),
    .rdata_c  (al_rdata_c),
    .cross_c  (al_cross_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      lo_q       <= ZeroWord;
      hi_q       <= ZeroWord;
      req_ready  <= 1'b1;
      stall_req  <= 1'b0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rdata <= ZeroWord;
      resp_rd    <= '0;
      resp_err   <= 1'b0;
      ram_ce     <= RamCeOff;
      ram_we     <= RamWeRead;
      ram_addr   <= ZeroWord;
      ram_sel    <= '0;
      ram_wdata  <= ZeroWord;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      req_ready  <= req_ready_d;
      stall_req  <= stall_req_d;
      resp_valid <= resp_valid_d;
      resp_we    <= resp_we_d;
      resp_rdata <= resp_rdata_d;
      resp_rd    <= resp_rd_d;
      resp_err   <= resp_err_d;
      ram_ce     <= ram_ce_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_sel    <= ram_sel_d;
      ram_wdata  <= ram_wdata_d;
    end
  end

  // Next state plus the registered RAM beat and response for the upcoming cycle.
  always_comb begin
    state_d      = ST_IDLE;
    req_d        = req_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    resp_valid_d = 1'b0;
    resp_we_d    = 1'b0;
    resp_rdata_d = ZeroWord;
    resp_rd_d    = '0;
    resp_err_d   = 1'b0;
    ram_ce_d     = RamCeOff;
    ram_we_d     = RamWeRead;
    ram_addr_d   = ZeroWord;
    ram_sel_d    = '0;
    ram_wdata_d  = ZeroWord;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (req_valid && req_ready) begin
          req_d.we     = req_we;
          req_d.funct3 = req_funct3;
          req_d.addr   = req_addr;
          req_d.wdata  = req_wdata;
          req_d.rd     = req_rd;
          if (f3_legal(req_we, req_funct3)) begin
            state_d     = ST_ACC0;
            ram_ce_d    = RamCeOn;
            ram_we_d    = req_we ? RamWeWrite : RamWeRead;
            ram_addr_d  = {req_addr[31:2], 2'b00};
            ram_sel_d   = al_sel_c;
            ram_wdata_d = al_wdata_c;
          end else begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_we_d    = req_we;
            resp_rd_d    = req_rd;
            resp_err_d   = 1'b1;
          end
        end
      end
      ST_ACC0: begin
        if (!req_q.we) lo_d = ram_rdata;
        if (al_cross_c) begin
          state_d     = ST_ACC1;
          ram_ce_d    = RamCeOn;
          ram_we_d    = req_q.we ? RamWeWrite : RamWeRead;
          ram_addr_d  = {req_q.addr[31:2], 2'b00} + XLEN'(4);
          ram_sel_d   = al_sel_c;
          ram_wdata_d = al_wdata_c;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_we_d    = req_q.we;
          resp_rd_d    = req_q.rd;
          resp_rdata_d = req_q.we ? ZeroWord : al_rdata_c;
        end
      end
      ST_ACC1: begin
        if (!req_q.we) hi_d = ram_rdata;
        state_d      = ST_RESP;
        resp_valid_d = 1'b1;
        resp_we_d    = req_q.we;
        resp_rd_d    = req_q.rd;
        resp_rdata_d = req_q.we ? ZeroWord : al_rdata_c;
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE) || (state_d == ST_RESP);
    stall_req_d = (state_d == ST_ACC0) || (state_d == ST_ACC1);
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu with a byte-lane RAM model and a response scoreboard.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_we, resp_err, stall_req;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [4:0]  rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_we    (resp_we),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .stall_req  (stall_req),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_sel    (ram_sel),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 64)  return 32'h1122_3344;
    if (i == 255) return 32'h3400_0000;
    if (i == 0)   return 32'h0000_0092;
    return 32'h0;
  endfunction

  // RAM: combinational read, lane-masked write on the edge ending a beat.
  assign ram_rdata = mem[ram_addr[9:2]];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (ram_ce && ram_we) begin
      for (int i = 0; i < 4; i++)
        if (ram_sel[i]) mem[ram_addr[9:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
    end
  end

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return w[8*int'(a[1:0]) +: 8];
  endfunction

  // Byte-at-a-time reference load, wrapping at the top of the address space.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 32'(i));
    if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input bit push);
    exp_t e;
    bit legal;
    legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
               : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    e.we    = we;
    e.err   = ~legal;
    e.rd    = rd;
    e.rdata = (legal && !we) ? exp_load(f3, addr) : 32'h0;
    if (push) sb.push_back(e);
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  task automatic beat_chk(input string t, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wdata);
    check({t, "_ce"},    32'(ram_ce), 32'd1);
    check({t, "_we"},    32'(ram_we), 32'(we));
    check({t, "_addr"},  ram_addr, addr);
    check({t, "_sel"},   32'(ram_sel), 32'(sel));
    check({t, "_wdata"}, ram_wdata, wdata);
    check({t, "_stall"}, 32'(stall_req), 32'd1);
    check({t, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic resp_chk(input string t);
    check({t, "_rvalid"}, 32'(resp_valid), 32'd1);
    check({t, "_stall"},  32'(stall_req), 32'd0);
    check({t, "_ready"},  32'(req_ready), 32'd1);
    check({t, "_ce"},     32'(ram_ce), 32'd0);
  endtask

  // Scoreboard: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("sb_we",    32'(resp_we), 32'(mon_e.we));
        check("sb_err",   32'(resp_err), 32'(mon_e.err));
        check("sb_rd",    32'(resp_rd), 32'(mon_e.rd));
        check("sb_rdata", resp_rdata, mon_e.rdata);
      end
    end else begin
      check("resp_idle_zero", {25'(resp_rdata != 32'h0), resp_rd, resp_we, resp_err}, 32'h0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    repeat (3) step();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_stall", 32'(stall_req), 32'd0);
    check("rst_ce",    32'(ram_ce), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    step();

    // Aligned LW: two-cycle latency, one stall cycle.
    issue(1'b0, 3'b010, 32'h0000_0100, 32'h0, 5'd1, 1'b1);
    beat_chk("lw", 1'b0, 32'h0000_0100, 4'b1111, 32'h0);
    step();
    resp_chk("lw");
    check("lw_rdata", resp_rdata, 32'h1122_3344);
    step();

    issue(1'b1, 3'b010, 32'h0000_0100, 32'h80AA_BBCC, 5'd0, 1'b1);
    beat_chk("sw_al", 1'b1, 32'h0000_0100, 4'b1111, 32'h80AA_BBCC);
    step();
    resp_chk("sw_al");
    step();
    check("sw_al_mem", mem[64], 32'h80AA_BBCC);

    // LB, LBU, LH accepted back-to-back in each RESP cycle.
    issue(1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd2, 1'b1);
    beat_chk("lb", 1'b0, 32'h0000_0100, 4'b1000, 32'h0);
    step();
    resp_chk("lb");
    check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
    issue(1'b0, 3'b100, 32'h0000_0103, 32'h0, 5'd3, 1'b1);
    beat_chk("lbu", 1'b0, 32'h0000_0100, 4'b1000, 32'h0);
    step();
    check("lbu_rdata", resp_rdata, 32'h0000_0080);
    issue(1'b0, 3'b001, 32'h0000_0102, 32'h0, 5'd4, 1'b1);
    beat_chk("lh_mid", 1'b0, 32'h0000_0100, 4'b1100, 32'h0);
    step();
    resp_chk("lh_mid");
    step();

    issue(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00EE, 5'd8, 1'b1);
    beat_chk("sb", 1'b1, 32'h0000_0100, 4'b0010, 32'h0000_EE00);
    step(); step();
    check("sb_mem", mem[64], 32'h80AA_EECC);

    // Split SW across 0x100/0x104.
    issue(1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd0, 1'b1);
    step(); step();
    issue(1'b1, 3'b010, 32'h0000_0104, 32'h0, 5'd0, 1'b1);
    step(); step();
    issue(1'b1, 3'b010, 32'h0000_0102, 32'hAABB_CCDD, 5'd5, 1'b1);
    beat_chk("sw_b1", 1'b1, 32'h0000_0100, 4'b1100, 32'hCCDD_0000);
    step();
    beat_chk("sw_b2", 1'b1, 32'h0000_0104, 4'b0011, 32'h0000_AABB);
    step();
    resp_chk("sw_split");
    check("sw_split_rdata", resp_rdata, 32'h0);
    step();
    check("sw_split_mem0", mem[64], 32'hCCDD_0000);
    check("sw_split_mem1", mem[65], 32'h0000_AABB);

    // LH wrapping from 0xFFFFFFFF to 0x00000000.
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 5'd6, 1'b1);
    beat_chk("lh_wrap_b1", 1'b0, 32'hFFFF_FFFC, 4'b1000, 32'h0);
    step();
    beat_chk("lh_wrap_b2", 1'b0, 32'h0000_0000, 4'b0001, 32'h0);
    step();
    resp_chk("lh_wrap");
    check("lh_wrap_rdata", resp_rdata, 32'hFFFF_9234);
    step();

    // Illegal encodings respond next cycle with no RAM access.
    issue(1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd7, 1'b1);
    check("ill_ld_ce", 32'(ram_ce), 32'd0);
    check("ill_ld_err", 32'(resp_err), 32'd1);
    resp_chk("ill_ld");
    step();
    issue(1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678, 5'd9, 1'b1);
    check("ill_st_ce", 32'(ram_ce), 32'd0);
    check("ill_st_err", 32'(resp_err), 32'd1);
    step();
    check("ill_st_mem", mem[64], 32'hCCDD_0000);

    // Reset during ACC1 of a split store: only the first beat lands.
    issue(1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd0, 1'b1);
    step(); step();
    issue(1'b1, 3'b010, 32'h0000_0104, 32'h0, 5'd0, 1'b1);
    step(); step();
    issue(1'b1, 3'b010, 32'h0000_0102, 32'hAABB_CCDD, 5'd5, 1'b0);
    step();
    check("rst_acc1_sel", 32'(ram_sel), 32'h3);
    rst_n = 1'b0;
    #1;
    check("rst_async_ce",    32'(ram_ce), 32'd0);
    check("rst_async_we",    32'(ram_we), 32'd0);
    check("rst_async_addr",  ram_addr, 32'h0);
    check("rst_async_sel",   32'(ram_sel), 32'd0);
    check("rst_async_wdata", ram_wdata, 32'h0);
    check("rst_async_stall", 32'(stall_req), 32'd0);
    check("rst_async_valid", 32'(resp_valid), 32'd0);
    step(); step();
    check("rst_part_mem0", mem[64], 32'hCCDD_0000);
    check("rst_part_mem1", mem[65], 32'h0);
    rst_n = 1'b1;
    step();
    check("rst_rel_ready", 32'(req_ready), 32'd1);
    check("rst_rel_stall", 32'(stall_req), 32'd0);

    repeat (3) step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
